// File: rtl/dmi_jtag_ctrl_q_pkg.sv
// -----------------------------------------------------------------------------
// dmi_jtag_ctrl_q_pkg
// Shared types and DR layout constants for the queued DMI request controller.
//   dtm_op_e      : DTM op encoding carried in the low bits of the DMI DR
//   dmi_error_e   : sticky error / response status encoding
//   dmi_state_e   : issue FSM states
//   DmiOp*/Dmi*   : field positions of {addr, data, op} inside the DR word
// -----------------------------------------------------------------------------
package dmi_jtag_ctrl_q_pkg;

  typedef enum logic [1:0] {
    DTM_NOP   = 2'h0,
    DTM_READ  = 2'h1,
    DTM_WRITE = 2'h2
  } dtm_op_e;

  typedef enum logic [1:0] {
    NoError  = 2'h0,
    Reserved = 2'h1,
    OpFailed = 2'h2,
    Busy     = 2'h3
  } dmi_error_e;

  typedef enum logic [1:0] {
    Idle     = 2'h0,
    Req      = 2'h1,
    WaitResp = 2'h2,
    Drain    = 2'h3
  } dmi_state_e;

  // DR word is {addr, data, op}; op and status share the low two bits.
  localparam int unsigned DmiOpWidth     = 2;
  localparam int unsigned DmiStatusWidth = 2;
  localparam int unsigned DmiDataLsb     = DmiOpWidth;

  function automatic int unsigned dmi_cmd_width(input int unsigned aw, input int unsigned dw);
    return aw + dw + DmiOpWidth;
  endfunction

  // Map a non-zero DMI response status onto the sticky error. The reserved
  // code 1 is reported to the debugger as a failed op.
  function automatic dmi_error_e status_to_error(input logic [1:0] status);
    dmi_error_e err;
    case (status)
      2'h0:    err = NoError;
      2'h3:    err = Busy;
      default: err = OpFailed;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/dmi_jtag_ctrl_q_cmd_fifo.sv
// -----------------------------------------------------------------------------
// dmi_cmd_fifo
// Small command queue, no fall-through: a pushed word becomes visible at the
// head one cycle after the push. Flush empties the queue synchronously.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   flush_i        synchronous flush (pointers and level cleared)
//   push_i/data_i  write port (ignored when full)
//   pop_i          advance head (ignored when empty)
//   data_o         head entry
//   full_o/empty_o occupancy flags, derived from the registered level
//   level_o        occupancy 0..Depth
// -----------------------------------------------------------------------------
module dmi_cmd_fifo #(
  parameter int unsigned Width = 41,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   level_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [PtrW:0]    r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign full_o    = (r_level == (PtrW+1)'(Depth));
  assign empty_o   = (r_level == '0);
  assign w_do_push = push_i && !full_o;
  assign w_do_pop  = pop_i && !empty_o;
  assign data_o    = r_mem[r_rptr];
  assign level_o   = r_level;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(Depth); i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= data_i;
        r_wptr        <= r_wptr + PtrW'(1);
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + PtrW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + (PtrW+1)'(1);
        2'b01:   r_level <= r_level - (PtrW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/dmi_jtag_ctrl_q.sv
// -----------------------------------------------------------------------------
// dmi_jtag_ctrl_q
// Queued DMI request controller in the TCK domain, between the DTM DR shift
// logic and dmi_cdc. Commands shifted in on Update-DR are queued and issued
// one at a time; writes are posted, reads report busy on capture until their
// response arrives. dmireset clears the sticky error, dmihardreset flushes.
// Optional build macro: DMI_JTAG_Q_TIMEOUT_EN adds a response watchdog of
// TimeoutCycles cycles in WaitResp/Drain.
// Ports:
//   clk_i, rst_i                 TCK clock, synchronous active-high reset
//   update_dr_i, capture_dr_i    DR strobes with the DMI IR selected
//   cmd_i                        shifted DR {addr, data, op}
//   dmi_reset_i, dmi_hardreset_i dtmcs strobes
//   capture_o                    DR capture word {last_addr, last_data, status}
//   error_o                      sticky error to dtmcs.dmistat
//   req_*                        DMI request channel towards dmi_cdc
//   resp_*                       DMI response channel from dmi_cdc
//   level_o                      queue occupancy
// -----------------------------------------------------------------------------
module dmi_jtag_ctrl_q
  import dmi_jtag_ctrl_q_pkg::*;
#(
  parameter int unsigned AddrWidth     = 7,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned Depth         = 4,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              update_dr_i,
  input  logic                              capture_dr_i,
  input  logic [AddrWidth+DataWidth+1:0]    cmd_i,
  input  logic                              dmi_reset_i,
  input  logic                              dmi_hardreset_i,
  output logic [AddrWidth+DataWidth+1:0]    capture_o,
  output logic [1:0]                        error_o,
  output logic                              req_valid_o,
  input  logic                              req_ready_i,
  output logic [AddrWidth-1:0]              req_addr_o,
  output logic [DataWidth-1:0]              req_data_o,
  output logic [1:0]                        req_op_o,
  input  logic                              resp_valid_i,
  output logic                              resp_ready_o,
  input  logic [DataWidth-1:0]              resp_data_i,
  input  logic [1:0]                        resp_status_i,
  output logic [$clog2(Depth):0]            level_o
);

  localparam int unsigned CmdWidth = dmi_cmd_width(AddrWidth, DataWidth);

  if ((Depth < 2) || ((Depth & (Depth - 1)) != 0)) begin : g_bad_depth
    $error("dmi_jtag_ctrl_q: Depth must be a power of two >= 2");
  end
  if (TimeoutCycles < 1) begin : g_bad_timeout
    $error("dmi_jtag_ctrl_q: TimeoutCycles must be >= 1");
  end

  dmi_state_e             r_state;
  logic                   r_req_valid;
  logic [AddrWidth-1:0]   r_req_addr;
  logic [DataWidth-1:0]   r_req_data;
  dtm_op_e                r_req_op;
  logic [AddrWidth-1:0]   r_last_addr;
  logic [DataWidth-1:0]   r_last_data;
  dmi_error_e             r_error;
  logic [CmdWidth-1:0]    r_capture;
  logic [$clog2(Depth):0] r_read_cnt;

  dtm_op_e                w_upd_op;
  logic                   w_upd_accept;
  logic                   w_push;
  logic                   w_drop;
  logic                   w_pop;
  logic                   w_resp_taken;
  logic                   w_to_hit;
  logic                   w_cap_busy;
  logic                   w_full;
  logic                   w_empty;
  logic [CmdWidth-1:0]    w_head;
  logic [$clog2(Depth):0] w_level;

  assign w_upd_op = dtm_op_e'(cmd_i[DmiOpWidth-1:0]);

  // Hardreset and a non-zero sticky error both swallow the update; NOP never queues.
  assign w_upd_accept = update_dr_i && !dmi_hardreset_i && (r_error == NoError) &&
                        ((w_upd_op == DTM_READ) || (w_upd_op == DTM_WRITE));
  assign w_push       = w_upd_accept && !w_full;
  assign w_drop       = w_upd_accept && w_full;
  assign w_resp_taken = (r_state == WaitResp) && resp_valid_i && !dmi_hardreset_i;
  assign w_cap_busy   = capture_dr_i && (r_read_cnt != '0);

`ifdef DMI_JTAG_Q_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TimeoutCycles + 1);
  logic [ToW-1:0] r_to_cnt;

  assign w_to_hit = ((r_state == WaitResp) || (r_state == Drain)) && !resp_valid_i &&
                    !dmi_hardreset_i && (r_to_cnt == ToW'(TimeoutCycles - 1));

  // Watchdog: counts waiting cycles, cleared whenever the wait is left or restarted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_to_cnt <= '0;
    end else if (dmi_hardreset_i || w_to_hit ||
                 !((r_state == WaitResp) || (r_state == Drain))) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + ToW'(1);
    end
  end
`else
  assign w_to_hit = 1'b0;
`endif

  // Only a watchdog expiry in WaitResp retires the head; in Drain it was already flushed.
  assign w_pop = w_resp_taken || (w_to_hit && (r_state == WaitResp));

  dmi_cmd_fifo #(
    .Width (CmdWidth),
    .Depth (Depth)
  ) u_cmd_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (dmi_hardreset_i),
    .push_i  (w_push),
    .data_i  (cmd_i),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .level_o (w_level)
  );

  // Issue FSM: registers the head into the request fields and tracks the response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= Idle;
      r_req_valid <= 1'b0;
      r_req_addr  <= '0;
      r_req_data  <= '0;
      r_req_op    <= DTM_NOP;
      r_last_addr <= '0;
      r_last_data <= '0;
    end else if (dmi_hardreset_i) begin
      // Dropping valid mid-request is intentional; dmi_cdc is flushed alongside.
      r_req_valid <= 1'b0;
      case (r_state)
        WaitResp: r_state <= Drain;
        Drain:    r_state <= Drain;
        default:  r_state <= Idle;
      endcase
    end else begin
      case (r_state)
        Idle: begin
          if (!w_empty) begin
            r_state     <= Req;
            r_req_valid <= 1'b1;
            r_req_addr  <= w_head[CmdWidth-1 -: AddrWidth];
            r_req_data  <= w_head[DmiDataLsb +: DataWidth];
            r_req_op    <= dtm_op_e'(w_head[DmiOpWidth-1:0]);
          end else begin
            r_state <= Idle;
          end
        end
        Req: begin
          if (req_ready_i) begin
            r_state     <= WaitResp;
            r_req_valid <= 1'b0;
          end else begin
            r_state <= Req;
          end
        end
        WaitResp: begin
          if (resp_valid_i) begin
            if ((r_req_op == DTM_READ) && (resp_status_i == 2'h0)) begin
              r_last_addr <= r_req_addr;
              r_last_data <= resp_data_i;
            end
            r_state <= Idle;
          end else if (w_to_hit) begin
            r_state <= Idle;
          end else begin
            r_state <= WaitResp;
          end
        end
        Drain: begin
          if (resp_valid_i || w_to_hit) begin
            r_state <= Idle;
          end else begin
            r_state <= Drain;
          end
        end
        default: begin
          r_state     <= Idle;
          r_req_valid <= 1'b0;
        end
      endcase
    end
  end

  // Number of READs queued or in flight; the in-flight op stays at the head until popped.
  always_ff @(posedge clk_i) begin
    if (rst_i || dmi_hardreset_i) begin
      r_read_cnt <= '0;
    end else begin
      case ({w_push && (w_upd_op == DTM_READ), w_pop && (r_req_op == DTM_READ)})
        2'b10:   r_read_cnt <= r_read_cnt + ($clog2(Depth)+1)'(1);
        2'b01:   r_read_cnt <= r_read_cnt - ($clog2(Depth)+1)'(1);
        default: r_read_cnt <= r_read_cnt;
      endcase
    end
  end

  // Sticky error: first error wins until a clear; clears beat any same-cycle setter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_error <= NoError;
    end else if (dmi_reset_i || dmi_hardreset_i) begin
      r_error <= NoError;
    end else if (r_error == NoError) begin
      if (w_drop || w_cap_busy) begin
        r_error <= Busy;
      end else if (w_resp_taken && (resp_status_i != 2'h0)) begin
        r_error <= status_to_error(resp_status_i);
      end else if (w_to_hit) begin
        r_error <= OpFailed;
      end else begin
        r_error <= r_error;
      end
    end else begin
      r_error <= r_error;
    end
  end

  // DR capture word; a pending READ reports busy in the same capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_capture <= '0;
    end else if (capture_dr_i) begin
      r_capture <= {r_last_addr, r_last_data, (w_cap_busy ? Busy : r_error)};
    end else begin
      r_capture <= r_capture;
    end
  end

  assign capture_o    = r_capture;
  assign error_o      = r_error;
  assign req_valid_o  = r_req_valid;
  assign req_addr_o   = r_req_addr;
  assign req_data_o   = r_req_data;
  assign req_op_o     = r_req_op;
  assign resp_ready_o = 1'b1;
  assign level_o      = w_level;

endmodule

// File: tb/tb_dmi_jtag_ctrl_q.sv
// -----------------------------------------------------------------------------
// tb_dmi_jtag_ctrl_q
// Directed self-checking bench for dmi_jtag_ctrl_q (Depth=4, TimeoutCycles=16).
// Inputs are driven after the falling edge, outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_dmi_jtag_ctrl_q;
  localparam int AW    = 7;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int TO    = 16;
  localparam logic [1:0] OP_NOP = 2'd0;
  localparam logic [1:0] OP_R   = 2'd1;
  localparam logic [1:0] OP_W   = 2'd2;

  logic              clk = 1'b0;
  logic              rst;
  logic              update_dr, capture_dr, dmi_reset, dmi_hardreset;
  logic [AW+DW+1:0]  cmd;
  logic [AW+DW+1:0]  capture;
  logic [1:0]        error;
  logic              req_valid, req_ready;
  logic [AW-1:0]     req_addr;
  logic [DW-1:0]     req_data;
  logic [1:0]        req_op;
  logic              resp_valid, resp_ready;
  logic [DW-1:0]     resp_data;
  logic [1:0]        resp_status;
  logic [$clog2(DEPTH):0] level;

  int n_tests = 0;
  int n_fail  = 0;

  dmi_jtag_ctrl_q #(
    .AddrWidth(AW), .DataWidth(DW), .Depth(DEPTH), .TimeoutCycles(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .update_dr_i(update_dr), .capture_dr_i(capture_dr),
    .cmd_i(cmd), .dmi_reset_i(dmi_reset), .dmi_hardreset_i(dmi_hardreset),
    .capture_o(capture), .error_o(error), .req_valid_o(req_valid),
    .req_ready_i(req_ready), .req_addr_o(req_addr), .req_data_o(req_data),
    .req_op_o(req_op), .resp_valid_i(resp_valid), .resp_ready_o(resp_ready),
    .resp_data_i(resp_data), .resp_status_i(resp_status), .level_o(level)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_update(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] op);
    cmd       = {a, d, op};
    update_dr = 1'b1;
    tick();
    update_dr = 1'b0;
  endtask

  task automatic do_capture();
    capture_dr = 1'b1;
    tick();
    capture_dr = 1'b0;
  endtask

  task automatic pulse_reset();
    dmi_reset = 1'b1;
    tick();
    dmi_reset = 1'b0;
  endtask

  task automatic pulse_hardreset();
    dmi_hardreset = 1'b1;
    tick();
    dmi_hardreset = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 20 && !req_valid; i++) tick();
    check_eq({tag, "_valid"}, 64'(req_valid), 64'd1);
  endtask

  // Wait for the request, check its fields, accept it, then answer it.
  task automatic serve(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [1:0] op, input logic [DW-1:0] rdata, input logic [1:0] st);
    wait_req(tag);
    check_eq({tag, "_addr"}, 64'(req_addr), 64'(a));
    check_eq({tag, "_data"}, 64'(req_data), 64'(d));
    check_eq({tag, "_op"},   64'(req_op),   64'(op));
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    resp_valid  = 1'b1;
    resp_data   = rdata;
    resp_status = st;
    tick();
    resp_valid  = 1'b0;
    resp_data   = '0;
    resp_status = 2'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    rst = 1'b1; update_dr = 1'b0; capture_dr = 1'b0; dmi_reset = 1'b0;
    dmi_hardreset = 1'b0; cmd = '0; req_ready = 1'b0; resp_valid = 1'b0;
    resp_data = '0; resp_status = 2'd0;
    @(negedge clk);
    tick();
    tick();
    check_eq("rst_error",   64'(error),     64'd0);
    check_eq("rst_valid",   64'(req_valid), 64'd0);
    check_eq("rst_level",   64'(level),     64'd0);
    check_eq("rst_capture", 64'(capture),   64'd0);
    check_eq("rst_resp_ready", 64'(resp_ready), 64'd1);
    rst = 1'b0;
    tick();

    // Write then read of the same address; two-cycle issue latency from empty.
    do_update(7'h10, 32'hDEADBEEF, OP_W);
    check_eq("t1_lat1_valid", 64'(req_valid), 64'd0);
    check_eq("t1_level1",     64'(level),     64'd1);
    tick();
    check_eq("t1_lat2_valid", 64'(req_valid), 64'd1);
    do_update(7'h10, 32'h0, OP_R);
    check_eq("t1_level2",     64'(level),     64'd2);
    check_eq("t1_hold_addr",  64'(req_addr),  64'h10);
    check_eq("t1_hold_data",  64'(req_data),  64'hDEADBEEF);
    serve("t1_wr", 7'h10, 32'hDEADBEEF, OP_W, 32'h0, 2'd0);
    serve("t1_rd", 7'h10, 32'h0, OP_R, 32'hDEADBEEF, 2'd0);
    do_capture();
    check_eq("t1_capture", 64'(capture), 64'({7'h10, 32'hDEADBEEF, 2'd0}));
    check_eq("t1_error",   64'(error),   64'd0);
    check_eq("t1_level0",  64'(level),   64'd0);

    // NOP is never queued.
    do_update(7'h11, 32'h1, OP_NOP);
    tick();
    check_eq("nop_level", 64'(level),     64'd0);
    check_eq("nop_valid", 64'(req_valid), 64'd0);

    // Five writes into a four-deep queue with the CDC stalled.
    for (int i = 0; i < 5; i++) do_update(7'(i + 1), 32'(32'h100 + i), OP_W);
    check_eq("t2_level_full", 64'(level), 64'd4);
    check_eq("t2_error_busy", 64'(error), 64'd3);
    pulse_reset();
    check_eq("t2_error_clr",  64'(error), 64'd0);
    for (int i = 0; i < 4; i++) serve("t2_drain", 7'(i + 1), 32'(32'h100 + i), OP_W, 32'h0, 2'd0);
    check_eq("t2_level0",     64'(level), 64'd0);

    // Capture with a read outstanding reports busy and makes it sticky.
    do_update(7'h22, 32'h0, OP_R);
    do_capture();
    check_eq("t3_capture_busy", 64'(capture), 64'({7'h10, 32'hDEADBEEF, 2'd3}));
    check_eq("t3_error_busy",   64'(error),   64'd3);
    do_update(7'h33, 32'h5, OP_W);
    check_eq("t3_ignored_level", 64'(level), 64'd1);
    serve("t3_rd", 7'h22, 32'h0, OP_R, 32'h12345678, 2'd0);
    check_eq("t3_error_sticky", 64'(error), 64'd3);
    check_eq("t3_level0",       64'(level), 64'd0);
    pulse_reset();
    check_eq("t3_error_clr",    64'(error), 64'd0);

    // Posted write: capture reports ok while the write is pending.
    do_update(7'h30, 32'hA5A5A5A5, OP_W);
    do_capture();
    check_eq("t4_capture", 64'(capture), 64'({7'h22, 32'h12345678, 2'd0}));
    check_eq("t4_error",   64'(error),   64'd0);
    serve("t4_wr", 7'h30, 32'hA5A5A5A5, OP_W, 32'h0, 2'd0);

    // Failed read response: error becomes failed, last data kept.
    do_update(7'h40, 32'h0, OP_R);
    serve("t5_rd", 7'h40, 32'h0, OP_R, 32'hCAFEF00D, 2'd2);
    check_eq("t5_error_failed", 64'(error), 64'd2);
    do_capture();
    check_eq("t5_capture", 64'(capture), 64'({7'h22, 32'h12345678, 2'd2}));
    pulse_reset();
    do_update(7'h41, 32'h0, OP_R);
    serve("t5_rd1", 7'h41, 32'h0, OP_R, 32'h00000BAD, 2'd1);
    check_eq("t5_status1_failed", 64'(error), 64'd2);
    pulse_reset();

    // Hardreset while waiting on a response with two more commands queued.
    do_update(7'h50, 32'h0, OP_R);
    do_update(7'h51, 32'h1, OP_W);
    do_update(7'h52, 32'h2, OP_W);
    wait_req("t6_req");
    check_eq("t6_addr", 64'(req_addr), 64'h50);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    check_eq("t6_level3", 64'(level), 64'd3);
    pulse_hardreset();
    check_eq("t6_level0", 64'(level),     64'd0);
    check_eq("t6_valid0", 64'(req_valid), 64'd0);
    resp_valid = 1'b1; resp_data = 32'h99; resp_status = 2'd2;
    tick();
    resp_valid = 1'b0; resp_data = '0; resp_status = 2'd0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (req_valid) seen = 1'b1;
      tick();
    end
    check_eq("t6_no_req",   64'(seen),  64'd0);
    check_eq("t6_error0",   64'(error), 64'd0);
    do_capture();
    check_eq("t6_capture",  64'(capture), 64'({7'h22, 32'h12345678, 2'd0}));
    do_update(7'h60, 32'h6, OP_W);
    serve("t6_after", 7'h60, 32'h6, OP_W, 32'h0, 2'd0);

    // Hardreset during Req withdraws the request and clears a sticky error.
    do_update(7'h70, 32'h7, OP_R);
    wait_req("t7_req");
    do_capture();
    check_eq("t7_error_busy", 64'(error), 64'd3);
    pulse_hardreset();
    check_eq("t7_valid0", 64'(req_valid), 64'd0);
    check_eq("t7_level0", 64'(level),     64'd0);
    check_eq("t7_error0", 64'(error),     64'd0);
    tick();

`ifdef DMI_JTAG_Q_TIMEOUT_EN
    // Watchdog: no response for TO cycles retires the read as failed.
    do_update(7'h78, 32'h0, OP_R);
    wait_req("t8_req");
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    for (int i = 0; i < TO - 1; i++) tick();
    check_eq("t8_error_before", 64'(error), 64'd0);
    tick();
    check_eq("t8_error_timeout", 64'(error), 64'd2);
    check_eq("t8_level0",        64'(level), 64'd0);
    pulse_reset();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmi_jtag_ctrl_q.md
Name: dmi_jtag_ctrl_q

Overview:
Parametrised DMI request controller for the JTAG DTM, clocked in the TCK domain. It replaces the single-outstanding-op FSM with a command queue, posted writes, per-response status capture and a hard-reset flush. It sits between the DTM TAP/DR shift logic (dmi_jtag_tap) and dmi_cdc. Address and data widths are generic.

Parameters:
AddrWidth, 7, DMI address width.
DataWidth, 32, DMI data width.
Depth, 4, command queue entries; power of two, ≥2.
TimeoutCycles, 1024, response watchdog limit; used only with the optional feature.

Ports:
clk_i  in  1  TCK-domain clock
rst_i  in  1  synchronous reset, active-high
update_dr_i  in  1  Update-DR with DMI IR selected
capture_dr_i  in  1  Capture-DR with DMI IR selected
cmd_i  in  AddrWidth+DataWidth+2  shifted DR: {addr, data, op}
dmi_reset_i  in  1  dtmcs.dmireset strobe; clears sticky error
dmi_hardreset_i  in  1  dtmcs.dmihardreset strobe; flushes queue
capture_o  out  AddrWidth+DataWidth+2  word loaded into DR on capture: {addr, data, status}
error_o  out  2  sticky error (0 none, 2 failed, 3 busy) to dtmcs.dmistat
req_valid_o  out  1  DMI request valid
req_ready_i  in  1  DMI request ready (from dmi_cdc)
req_addr_o  out  AddrWidth  request address
req_data_o  out  DataWidth  request write data
req_op_o  out  2  request op (dm::DTM_READ / dm::DTM_WRITE)
resp_valid_i  in  1  DMI response valid
resp_ready_o  out  1  tied 1
resp_data_i  in  DataWidth  response data
resp_status_i  in  2  response status (0 ok, 2 failed, 3 busy)
level_o  out  $clog2(Depth)+1  queue occupancy

Behaviour:
- Reset: error_o=0, req_valid_o=0, level_o=0, capture_o=0, FSM in Idle, last_addr/last_data=0. All sequential state resets on rst_i at the clk_i edge.
- Push: on update_dr_i with error_q==0 and op∈{READ,WRITE}:
  - if level<Depth, push {addr,data,op}.
  - if full, drop the command and set error=busy.
- NOP on update_dr_i never pushes.
- Any update_dr_i while error_q≠0 is ignored. The error stays.
- Full is judged on registered level. A pop in the same cycle does not make room.
- Issue FSM:
  - Idle: if level>0, go to Req next cycle.
  - Req: req_valid_o=1, fields driven from the head entry. Fields hold stable until req_ready_i. On handshake, go to WaitResp.
  - WaitResp: on resp_valid_i, pop head.
    - If READ and status==0: last_data←resp_data_i, last_addr←head addr.
    - If status≠0 and error_q==0: error←status (1 maps to failed).
    - Go to Idle.
  - Drain: entered on dmi_hardreset_i while in WaitResp. Discards the next response, then goes to Idle.
- Latency: push to req_valid_o is 2 cycles from empty. Back-to-back ops cost a minimum of 3 cycles each (Req, WaitResp, Idle).
- Posted writes: capture_dr_i with only writes pending gives status 0.
- Capture: capture_o={last_addr,last_data,st}.
  - st=3 and error←busy if any READ is queued or in flight.
  - Otherwise st=error_q.
  - Busy set in the same cycle is reflected in st.
- dmi_reset_i clears error to 0. If it coincides with a busy-setting event, the clear wins.
- dmi_hardreset_i:
  - level←0.
  - If in Req, drop to Idle with req_valid_o deasserted. This violates valid-hold by design; dmi_cdc is flushed alongside.
  - If in WaitResp, go to Drain.
  - error is cleared.
  - A coincident update_dr_i is ignored.
- Pointers wrap modulo Depth; level counts 0..Depth.

Optional Feature:
- Macro: DMI_JTAG_Q_TIMEOUT_EN.
- Enabled: a counter runs in WaitResp/Drain and is cleared on entry. At TimeoutCycles without resp_valid_i:
  - pop head (WaitResp only);
  - error←failed if 0;
  - go to Idle.
  - A late response arriving in Idle is discarded.
- Disabled: no counter. WaitResp waits indefinitely.

Decomposition:
- Package dm gains:
  - dmi_error_e (NoError, Reserved, OpFailed, Busy);
  - the parametrisable cmd layout constants;
  - reuse of existing dm::dtm_op_e.
- Sub-module dmi_cmd_fifo:
  - parametrised width/depth;
  - push/pop/full/empty/level;
  - synchronous active-high flush;
  - no fall-through.

Test Plan:
- Write 0x10←0xDEADBEEF then read 0x10 with resp 0xDEADBEEF: two DMI requests in order. Next capture gives {0x10,0xDEADBEEF,0}.
- 5 writes with Depth=4 and req_ready_i held 0: 5th dropped, error_o=3, level_o=4. dmi_reset_i then gives error_o=0; queue drains 4 writes.
- Read queued, capture_dr_i before response: capture status 3, error_o=3 sticky. Later updates ignored until dmi_reset_i.
- Write pending, capture_dr_i: status 0, no error.
- Read response status 2: error_o=2; last_data unchanged.
- dmi_hardreset_i in WaitResp with 2 queued: level_o=0, late response discarded, no request issued. With DMI_JTAG_Q_TIMEOUT_EN and TimeoutCycles=16, no response gives error_o=2 at cycle 16.
